// File: rtl/ls_exec_unit_pkg.sv
// Shared definitions for the load/store execution stage: opcode ids, access
// sizes, FSM state codes and default widths.
package ls_exec_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int OP_W_DEF  = 6;
  localparam int ROB_W_DEF = 4;

  localparam int OP_LB  = 0;
  localparam int OP_LH  = 1;
  localparam int OP_LW  = 2;
  localparam int OP_LBU = 3;
  localparam int OP_LHU = 4;
  localparam int OP_SB  = 5;
  localparam int OP_SH  = 6;
  localparam int OP_SW  = 7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LD_REQ    = 3'd1;
  localparam logic [2:0] S_ST_REPORT = 3'd2;
  localparam logic [2:0] S_ST_WAIT   = 3'd3;
  localparam logic [2:0] S_ST_REQ    = 3'd4;
  localparam logic [2:0] S_MEM_WAIT  = 3'd5;
  localparam logic [2:0] S_EXC       = 3'd6;

endpackage

// File: rtl/ls_exec_unit_if.sv
// Memory-controller request/response bus of the load/store execution stage.
interface ls_exec_unit_if #(parameter int XLEN = 32);
  logic            mem_req_valid;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [1:0]      mem_req_size;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_size, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_size, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/ls_exec_unit_load_extend.sv
// Sign/zero extension of LSB-aligned raw load data according to the opcode.
module ls_load_extend
  import ls_exec_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] value
);

  // Unknown ids fall through to the word case and pass the data unchanged.
  always_comb begin
    value = raw;
    case (op)
      OP_W'(OP_LB):  value = {{(XLEN-8){raw[7]}}, raw[7:0]};
      OP_W'(OP_LH):  value = {{(XLEN-16){raw[15]}}, raw[15:0]};
      OP_W'(OP_LBU): value = {{(XLEN-8){1'b0}}, raw[7:0]};
      OP_W'(OP_LHU): value = {{(XLEN-16){1'b0}}, raw[15:0]};
      default:       value = raw;
    endcase
  end

endmodule

// File: rtl/ls_exec_unit.sv
// Load/store execution stage: address generation, memory handshake, load
// extension and ROB broadcast. Optional macro: LS_MISALIGN_CHECK_EN.
module ls_exec_unit
  import ls_exec_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int ROB_W = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op_id,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [ROB_W-1:0] in_rob_id,
  output logic             ready,
  ls_exec_unit_if.master   mem,
  output logic             rob_out_valid,
  output logic [ROB_W-1:0] rob_out_id,
  output logic [XLEN-1:0]  rob_out_value,
  input  logic             rob_store_commit,
  input  logic [ROB_W-1:0] rob_store_commit_id,
  input  logic             roll_back
`ifdef LS_MISALIGN_CHECK_EN
  ,
  output logic             rob_out_exc
`endif
);

  logic [2:0]      state;
  logic [OP_W-1:0] op_q;
  logic [ROB_W-1:0] id_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] eff_addr;
  logic [XLEN-1:0] load_val;

  function automatic logic [1:0] size_of(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(OP_LB), OP_W'(OP_LBU), OP_W'(OP_SB): return SZ_BYTE;
      OP_W'(OP_LH), OP_W'(OP_LHU), OP_W'(OP_SH): return SZ_HALF;
      default:                                   return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_SB)) || (op == OP_W'(OP_SH)) || (op == OP_W'(OP_SW));
  endfunction

  function automatic logic [XLEN-1:0] mask_wdata(input logic [OP_W-1:0] op,
                                                 input logic [XLEN-1:0] d);
    case (size_of(op))
      SZ_BYTE: return XLEN'(d[7:0]);
      SZ_HALF: return XLEN'(d[15:0]);
      default: return d;
    endcase
  endfunction

`ifdef LS_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
    logic [1:0] sz;
    sz = size_of(op);
    return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
  endfunction
`endif

  assign eff_addr = in_rs1 + in_imm;

  ls_load_extend #(.XLEN(XLEN), .OP_W(OP_W)) u_load_extend (
    .op    (op_q),
    .raw   (mem.mem_resp_rdata),
    .value (load_val)
  );

  // The request fields come straight from the latched op so they stay stable
  // for the whole handshake.
  assign ready             = (state == S_IDLE);
  assign mem.mem_req_valid = (state == S_LD_REQ) || (state == S_ST_REQ);
  assign mem.mem_req_we    = is_store(op_q);
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_size  = size_of(op_q);
  assign mem.mem_req_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= '0;
      id_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rob_out_valid <= 1'b0;
      rob_out_id    <= '0;
      rob_out_value <= '0;
`ifdef LS_MISALIGN_CHECK_EN
      rob_out_exc   <= 1'b0;
`endif
    end else if (rdy) begin
      rob_out_valid <= 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
      rob_out_exc   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (in_valid && !roll_back) begin
            op_q    <= in_op_id;
            id_q    <= in_rob_id;
            addr_q  <= eff_addr;
            wdata_q <= mask_wdata(in_op_id, in_rs2);
`ifdef LS_MISALIGN_CHECK_EN
            if (misaligned(in_op_id, eff_addr[1:0])) begin
              state         <= S_EXC;
              rob_out_valid <= 1'b1;
              rob_out_exc   <= 1'b1;
              rob_out_id    <= in_rob_id;
              rob_out_value <= '0;
            end else
`endif
            if (is_store(in_op_id)) begin
              state         <= S_ST_REPORT;
              rob_out_valid <= 1'b1;
              rob_out_id    <= in_rob_id;
              rob_out_value <= '0;
            end else begin
              state <= S_LD_REQ;
            end
          end
        end
        S_LD_REQ: begin
          if (roll_back)              state <= S_IDLE;
          else if (mem.mem_req_ready) state <= S_MEM_WAIT;
        end
        S_ST_REPORT: state <= roll_back ? S_IDLE : S_ST_WAIT;
        // A matching commit beats a simultaneous flush: the store is architectural.
        S_ST_WAIT: begin
          if (rob_store_commit && (rob_store_commit_id == id_q)) state <= S_ST_REQ;
          else if (roll_back)                                    state <= S_IDLE;
        end
        S_ST_REQ: begin
          if (mem.mem_req_ready) state <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (is_store(op_q)) begin
            if (mem.mem_resp_valid) state <= S_IDLE;
          end else if (roll_back) begin
            state <= S_IDLE;
          end else if (mem.mem_resp_valid) begin
            state         <= S_IDLE;
            rob_out_valid <= 1'b1;
            rob_out_id    <= id_q;
            rob_out_value <= load_val;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
